ps2_tx: RTL and testbench
=========================

PS2_TX -- requirements
Module: ps2_tx

Interface
REQ-001 Parameter INHIBIT_CYCLES, default 5000, Clk cycles the clock line is held low before the start bit (100 us at 50 MHz).
REQ-002 Parameter TIMEOUT_CYCLES, default 750000, Clk cycles without a device clock falling edge before the frame is aborted (15 ms at 50 MHz).
REQ-003 Clk  in  1  system clock; the block has one clock, and all state changes on its rising edge.
REQ-004 Reset  in  1  reset, synchronous and active-high.
REQ-005 ps2_nclk  in  1  raw PS/2 clock line level (1 = released/high), asynchronous to Clk.
REQ-006 ndata  in  1  raw PS/2 data line level, asynchronous to Clk.
REQ-007 tx_data  in  8  byte to send to the device.
REQ-008 tx_valid  in  1  request; accepted when tx_valid and tx_ready are both 1 in one cycle.
REQ-009 tx_ready  out  1  idle; able to accept a byte.
REQ-010 clk_drv_low  out  1  1 = pull the PS/2 clock line low (open-drain enable).
REQ-011 data_drv_low  out  1  1 = pull the PS/2 data line low.
REQ-012 tx_done  out  1  one-cycle pulse when the frame completes with the device ACK.
REQ-013 tx_err  out  1  one-cycle pulse when the frame ends without ACK or on timeout.

Function
REQ-014 Both line inputs SHALL pass through a 2-flop synchronizer; a "fall" event is a synchronized 1->0 transition of ps2_nclk.
REQ-015 States SHALL be IDLE, INHIBIT, START, DATA, PARITY, STOP, ACK, WAIT_REL, DONE and ERR.
REQ-016 IDLE: tx_ready=1 and both drives 0; on accept, latch tx_data, compute odd parity (parity = ~^tx_data) and go to INHIBIT.
REQ-017 INHIBIT: clk_drv_low=1 for exactly INHIBIT_CYCLES cycles; in the last cycle data_drv_low becomes 1; then go to START with clk_drv_low=0.
REQ-018 START: hold data_drv_low=1; the first fall loads bit0 onto data and goes to DATA with bit count 1.
REQ-019 DATA: each fall puts the next bit on data, LSB first (data_drv_low = ~bit); the fall after bit7 puts parity on data and goes to PARITY.
REQ-020 PARITY: the next fall releases data (stop bit = 1) and goes to STOP.
REQ-021 STOP: the next fall samples synchronized ndata; 0 goes to ACK, 1 goes to ERR.
REQ-022 ACK: wait for synchronized ps2_nclk=1 and ndata=1, then go to DONE.
REQ-023 DONE and ERR SHALL each last one cycle, pulse tx_done or tx_err respectively, and return to IDLE; tx_ready SHALL be 1 again in the following cycle.
REQ-024 data_drv_low and clk_drv_low SHALL be registered outputs and SHALL never both be 0 during INHIBIT.
REQ-025 tx_valid while tx_ready=0 SHALL be ignored; tx_data SHALL be sampled only at accept.
REQ-026 tx_done and tx_err SHALL never be asserted in the same cycle.

Reset
REQ-027 On Reset=1 at a rising edge, mid-frame included: state=IDLE, tx_ready=1, clk_drv_low=0, data_drv_low=0, tx_done=0, tx_err=0, counters=0, synchronizers=1.

Configuration
REQ-028 With PS2_TX_TIMEOUT_EN defined: in START, DATA, PARITY, STOP and ACK, a counter cleared on every fall SHALL go to ERR when it reaches TIMEOUT_CYCLES, releasing both lines.
REQ-029 Without PS2_TX_TIMEOUT_EN: no timeout counter exists, and the block waits indefinitely for device clock edges.

Structure
REQ-030 Package ps2_pkg SHALL hold the state enum type, default INHIBIT_CYCLES and TIMEOUT_CYCLES constants, and a localparam for frame bit count (11).
REQ-031 Sub-module ps2_line_sync SHALL contain the 2-flop synchronizer and fall detector; ps2_tx instantiates it once per line.

Verification
REQ-032 tx_data=0xED accepted -> clk low 5000 cycles; data low; on device falls the line shows 1,0,1,1,0,1,1,1, parity 1, stop 1; device ACK -> one tx_done pulse.
REQ-033 tx_data=0x01 -> parity bit 0; tx_data=0x00 -> parity bit 1.
REQ-034 Device never pulls data low at the 11th fall -> tx_err pulse, no tx_done, tx_ready=1 next cycle.
REQ-035 PS2_TX_TIMEOUT_EN with TIMEOUT_CYCLES=1000; device stops clocking after bit3 -> tx_err exactly 1000 cycles after the last fall, drives 0.
REQ-036 Reset asserted during DATA bit5 -> next cycle both drives 0 and tx_ready=1; a new tx_valid with 0x55 completes normally.
REQ-037 tx_valid held with 0xAA while busy with 0x12 -> 0x12 frame unaffected; 0xAA accepted only after tx_done.

Source files
------------

// File: rtl/ps2_pkg.sv
// ps2_pkg: shared state type, default timing constants and parity helper for ps2_tx
package ps2_pkg;
  typedef enum logic [3:0] {
    S_IDLE, S_INHIBIT, S_START, S_DATA, S_PARITY, S_STOP, S_ACK, S_WAIT_REL, S_DONE, S_ERR
  } state_e;
  localparam int INHIBIT_CYCLES_DEF = 5000;
  localparam int TIMEOUT_CYCLES_DEF = 750000;
  localparam int FRAME_BITS = 11;
  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction
endpackage

// File: rtl/ps2_tx_if.sv
// ps2_tx_if: byte request/response handshake and open-drain PS/2 line signals of ps2_tx
interface ps2_tx_if;
  logic [7:0] tx_data;
  logic tx_valid;
  logic tx_ready;
  logic tx_done;
  logic tx_err;
  logic clk_drv_low;
  logic data_drv_low;
  logic ps2_nclk;
  logic ndata;
  modport master (
    output tx_data, tx_valid, ps2_nclk, ndata,
    input  tx_ready, tx_done, tx_err, clk_drv_low, data_drv_low
  );
  modport slave (
    input  tx_data, tx_valid, ps2_nclk, ndata,
    output tx_ready, tx_done, tx_err, clk_drv_low, data_drv_low
  );
endinterface

// File: rtl/ps2_line_sync.sv
// ps2_line_sync: 2-flop synchronizer for one raw PS/2 line plus a 1->0 edge detector
module ps2_line_sync (
  input  logic Clk,
  input  logic Reset,
  input  logic line_i,
  output logic level_o,
  output logic fall_o
);
  logic [2:0] sync_q;
  always_ff @(posedge Clk) begin
    if (Reset) sync_q <= '1;
    else sync_q <= {sync_q[1:0], line_i};
  end
  assign level_o = sync_q[1];
  assign fall_o = sync_q[2] & ~sync_q[1];
endmodule

// File: rtl/ps2_tx.sv
// ps2_tx: PS/2 host-to-device byte transmitter (inhibit, start, 8 data LSB first, odd parity, stop, ACK).
// Define PS2_TX_TIMEOUT_EN to abort a frame when the device stops clocking for TIMEOUT_CYCLES.
module ps2_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = INHIBIT_CYCLES_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input logic Clk,
  input logic Reset,
  ps2_tx_if.slave bus
);
  localparam int IW = $clog2(INHIBIT_CYCLES + 1);
  state_e state_q, state_d;
  logic [IW-1:0] cnt_q, cnt_d;
  logic [3:0] bit_q, bit_d;
  logic [8:0] sh_q, sh_d;
  logic clk_drv_q, clk_drv_d, data_drv_q, data_drv_d;
  logic clk_lvl, clk_fall, data_lvl, data_fall_unused;
  ps2_line_sync u_clk_sync (.Clk, .Reset, .line_i(bus.ps2_nclk), .level_o(clk_lvl), .fall_o(clk_fall));
  ps2_line_sync u_data_sync (.Clk, .Reset, .line_i(bus.ndata), .level_o(data_lvl), .fall_o(data_fall_unused));
`ifdef PS2_TX_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tout_q, tout_d;
  logic in_frame;
  assign in_frame = state_q inside {S_START, S_DATA, S_PARITY, S_STOP, S_ACK};
  always_ff @(posedge Clk) begin
    if (Reset) tout_q <= '0;
    else tout_q <= tout_d;
  end
`else
  localparam int TIMEOUT_UNUSED = TIMEOUT_CYCLES;
`endif
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    bit_d = bit_q;
    sh_d = sh_q;
    clk_drv_d = clk_drv_q;
    data_drv_d = data_drv_q;
    case (state_q)
      S_IDLE: if (bus.tx_valid) begin
        state_d = S_INHIBIT;
        cnt_d = '0;
        bit_d = '0;
        sh_d = {odd_parity(bus.tx_data), bus.tx_data};
        clk_drv_d = 1'b1;
        data_drv_d = INHIBIT_CYCLES == 1;
      end
      // data goes low one cycle before the clock is released, so the start bit is already set up
      S_INHIBIT: begin
        cnt_d = cnt_q + 1'b1;
        data_drv_d = cnt_q == IW'(INHIBIT_CYCLES - 2);
        if (cnt_q == IW'(INHIBIT_CYCLES - 1)) begin
          state_d = S_START;
          clk_drv_d = 1'b0;
          data_drv_d = 1'b1;
        end
      end
      S_START, S_DATA: if (clk_fall) begin
        data_drv_d = ~sh_q[0];
        sh_d = {1'b0, sh_q[8:1]};
        bit_d = bit_q + 1'b1;
        state_d = (state_q == S_START) ? S_DATA : (bit_q == 4'(FRAME_BITS - 3)) ? S_PARITY : S_DATA;
      end
      S_PARITY: if (clk_fall) begin
        data_drv_d = 1'b0;
        state_d = S_STOP;
      end
      S_STOP: if (clk_fall) state_d = data_lvl ? S_ERR : S_ACK;
      S_ACK: if (clk_lvl && data_lvl) state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
`ifdef PS2_TX_TIMEOUT_EN
    tout_d = (in_frame && !clk_fall) ? tout_q + 1'b1 : '0;
    if (in_frame && !clk_fall && tout_q == TW'(TIMEOUT_CYCLES - 1)) begin
      state_d = S_ERR;
      clk_drv_d = 1'b0;
      data_drv_d = 1'b0;
    end
`endif
  end
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= S_IDLE;
      cnt_q <= '0;
      bit_q <= '0;
      sh_q <= '0;
      clk_drv_q <= 1'b0;
      data_drv_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      bit_q <= bit_d;
      sh_q <= sh_d;
      clk_drv_q <= clk_drv_d;
      data_drv_q <= data_drv_d;
    end
  end
  assign bus.tx_ready = state_q == S_IDLE;
  assign bus.tx_done = state_q == S_DONE;
  assign bus.tx_err = state_q == S_ERR;
  assign bus.clk_drv_low = clk_drv_q;
  assign bus.data_drv_low = data_drv_q;
endmodule

// File: tb/tb_ps2_tx.sv
// tb_ps2_tx: directed self-checking bench for ps2_tx driven by a behavioural open-drain PS/2 device
`timescale 1ns/1ps
module tb_ps2_tx;
  localparam int H = 20;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic dev_clk = 1'b1;
  logic dev_data = 1'b1;
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int done_cnt = 0, err_cnt = 0, both_cnt = 0, done_cyc = 0, err_cyc = 0, last_acc = 0;
  logic rdy_after = 1'b0, pulse_prev = 1'b0;
  ps2_tx_if bus();
  assign bus.ps2_nclk = dev_clk & ~bus.clk_drv_low;
  assign bus.ndata = dev_data & ~bus.data_drv_low;
  ps2_tx #(.TIMEOUT_CYCLES(1000)) dut (.Clk(clk), .Reset(rst), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (bus.tx_done) begin done_cnt++; done_cyc = cyc; end
    if (bus.tx_err) begin err_cnt++; err_cyc = cyc; end
    if (bus.tx_done && bus.tx_err) both_cnt++;
    if (bus.tx_valid && bus.tx_ready) last_acc = cyc;
    if (pulse_prev) rdy_after = bus.tx_ready;
    pulse_prev = bus.tx_done | bus.tx_err;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Device clocks nfalls falling edges; returns right after the last fall with the clock held low.
  task automatic device(input int nfalls, input logic ack, output logic [9:0] seen);
    seen = '0;
    tick(H);
    for (int i = 1; i <= nfalls; i++) begin
      if (i == 11) dev_data = ~ack;
      dev_clk = 1'b0;
      if (i == nfalls) break;
      tick(H);
      seen[i-1] = ~bus.data_drv_low;
      dev_clk = 1'b1;
      tick(H);
    end
  endtask

  task automatic accept(input logic [7:0] d, input logic [7:0] nxt, input logic hold);
    int n;
    bus.tx_data = d;
    bus.tx_valid = 1'b1;
    n = 0;
    while (!bus.tx_ready && n < 100) begin tick(1); n++; end
    tick(1);
    bus.tx_data = nxt;
    bus.tx_valid = hold;
  endtask

  task automatic finish_frame(input logic ack, output int inh, output int both, output logic start_drv,
                              output logic [9:0] seen);
    inh = 0;
    both = 0;
    while (bus.clk_drv_low && inh < 6000) begin
      inh++;
      if (bus.data_drv_low) both++;
      tick(1);
    end
    start_drv = bus.data_drv_low;
    device(11, ack, seen);
    tick(H);
    dev_clk = 1'b1;
    tick(H);
    dev_data = 1'b1;
    tick(20);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(3);
    checks++; if (bus.tx_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", bus.tx_ready); end
    checks++; if (bus.clk_drv_low !== 1'b0) begin errors++; $display("FAIL reset_clk_drv: got %b want 0", bus.clk_drv_low); end
    checks++; if (bus.data_drv_low !== 1'b0) begin errors++; $display("FAIL reset_data_drv: got %b want 0", bus.data_drv_low); end
    checks++; if (bus.tx_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", bus.tx_done); end
    checks++; if (bus.tx_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", bus.tx_err); end
    rst = 1'b0;
    tick(3);
  endtask

  task automatic test_frame_ed();
    int inh, both, d0, e0;
    logic sd;
    logic [9:0] seen;
    d0 = done_cnt; e0 = err_cnt;
    accept(8'hED, 8'h00, 1'b0);
    finish_frame(1'b1, inh, both, sd, seen);
    checks++; if (inh !== 5000) begin errors++; $display("FAIL ed_inhibit_len: got %0d want 5000", inh); end
    checks++; if (both !== 1) begin errors++; $display("FAIL ed_data_low_last_inhibit: got %0d want 1", both); end
    checks++; if (sd !== 1'b1) begin errors++; $display("FAIL ed_start_drv: got %b want 1", sd); end
    checks++; if (seen !== 10'h3ED) begin errors++; $display("FAIL ed_bits: got %h want 3ed", seen); end
    checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL ed_done: got %0d want 1", done_cnt - d0); end
    checks++; if (err_cnt - e0 !== 0) begin errors++; $display("FAIL ed_err: got %0d want 0", err_cnt - e0); end
    checks++; if (rdy_after !== 1'b1) begin errors++; $display("FAIL ed_ready_after: got %b want 1", rdy_after); end
  endtask

  task automatic test_parity();
    int inh, both, d0;
    logic sd;
    logic [9:0] seen;
    d0 = done_cnt;
    accept(8'h01, 8'hFF, 1'b0);
    finish_frame(1'b1, inh, both, sd, seen);
    checks++; if (seen !== 10'h201) begin errors++; $display("FAIL par01_bits: got %h want 201", seen); end
    accept(8'h00, 8'hFF, 1'b0);
    finish_frame(1'b1, inh, both, sd, seen);
    checks++; if (seen !== 10'h300) begin errors++; $display("FAIL par00_bits: got %h want 300", seen); end
    checks++; if (done_cnt - d0 !== 2) begin errors++; $display("FAIL par_done: got %0d want 2", done_cnt - d0); end
  endtask

  task automatic test_no_ack();
    int inh, both, d0, e0;
    logic sd;
    logic [9:0] seen;
    d0 = done_cnt; e0 = err_cnt;
    accept(8'h3C, 8'h00, 1'b0);
    finish_frame(1'b0, inh, both, sd, seen);
    checks++; if (seen !== 10'h33C) begin errors++; $display("FAIL noack_bits: got %h want 33c", seen); end
    checks++; if (err_cnt - e0 !== 1) begin errors++; $display("FAIL noack_err: got %0d want 1", err_cnt - e0); end
    checks++; if (done_cnt - d0 !== 0) begin errors++; $display("FAIL noack_done: got %0d want 0", done_cnt - d0); end
    checks++; if (rdy_after !== 1'b1) begin errors++; $display("FAIL noack_ready_after: got %b want 1", rdy_after); end
  endtask

  task automatic test_reset_mid_frame();
    int n, inh, both, d0;
    logic sd;
    logic [9:0] seen;
    accept(8'h13, 8'h00, 1'b0);
    n = 0;
    while (bus.clk_drv_low && n < 6000) begin tick(1); n++; end
    device(6, 1'b1, seen);
    tick(H);
    checks++; if (bus.data_drv_low !== 1'b1) begin errors++; $display("FAIL mid_bit5_drv: got %b want 1", bus.data_drv_low); end
    rst = 1'b1;
    tick(1);
    checks++; if (bus.clk_drv_low !== 1'b0) begin errors++; $display("FAIL mid_reset_clk_drv: got %b want 0", bus.clk_drv_low); end
    checks++; if (bus.data_drv_low !== 1'b0) begin errors++; $display("FAIL mid_reset_data_drv: got %b want 0", bus.data_drv_low); end
    checks++; if (bus.tx_ready !== 1'b1) begin errors++; $display("FAIL mid_reset_ready: got %b want 1", bus.tx_ready); end
    rst = 1'b0;
    dev_clk = 1'b1;
    tick(5);
    d0 = done_cnt;
    accept(8'h55, 8'h00, 1'b0);
    finish_frame(1'b1, inh, both, sd, seen);
    checks++; if (seen !== 10'h355) begin errors++; $display("FAIL mid_55_bits: got %h want 355", seen); end
    checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL mid_55_done: got %0d want 1", done_cnt - d0); end
  endtask

  task automatic test_back_to_back();
    int inh, both, d0;
    logic sd;
    logic [9:0] seen;
    d0 = done_cnt;
    accept(8'h12, 8'hAA, 1'b1);
    finish_frame(1'b1, inh, both, sd, seen);
    bus.tx_valid = 1'b0;
    checks++; if (seen !== 10'h312) begin errors++; $display("FAIL b2b_12_bits: got %h want 312", seen); end
    checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL b2b_12_done: got %0d want 1", done_cnt - d0); end
    checks++; if (last_acc - done_cyc !== 1) begin errors++; $display("FAIL b2b_accept_after_done: got %0d want 1", last_acc - done_cyc); end
    checks++; if (bus.clk_drv_low !== 1'b1) begin errors++; $display("FAIL b2b_aa_inhibit: got %b want 1", bus.clk_drv_low); end
    finish_frame(1'b1, inh, both, sd, seen);
    checks++; if (seen !== 10'h3AA) begin errors++; $display("FAIL b2b_aa_bits: got %h want 3aa", seen); end
    checks++; if (done_cnt - d0 !== 2) begin errors++; $display("FAIL b2b_aa_done: got %0d want 2", done_cnt - d0); end
  endtask

`ifdef PS2_TX_TIMEOUT_EN
  task automatic test_timeout();
    int n, c0, d0, e0;
    logic [9:0] seen;
    d0 = done_cnt; e0 = err_cnt;
    accept(8'h08, 8'h00, 1'b0);
    n = 0;
    while (bus.clk_drv_low && n < 6000) begin tick(1); n++; end
    device(4, 1'b1, seen);
    n = 0;
    while (bus.data_drv_low && n < 20) begin tick(1); n++; end
    c0 = cyc;
    checks++; if (n >= 20) begin errors++; $display("FAIL to_bit3_drv: got %0d cycles want <20", n); end
    n = 0;
    while (!bus.tx_err && n < 2000) begin tick(1); n++; end
    checks++; if (bus.tx_err !== 1'b1) begin errors++; $display("FAIL to_err_seen: got %b want 1", bus.tx_err); end
    checks++; if (cyc - c0 !== 1000) begin errors++; $display("FAIL to_latency: got %0d want 1000", cyc - c0); end
    checks++; if (bus.clk_drv_low !== 1'b0) begin errors++; $display("FAIL to_clk_drv: got %b want 0", bus.clk_drv_low); end
    checks++; if (bus.data_drv_low !== 1'b0) begin errors++; $display("FAIL to_data_drv: got %b want 0", bus.data_drv_low); end
    dev_clk = 1'b1;
    tick(10);
    checks++; if (done_cnt - d0 !== 0) begin errors++; $display("FAIL to_done: got %0d want 0", done_cnt - d0); end
    checks++; if (err_cnt - e0 !== 1) begin errors++; $display("FAIL to_err_count: got %0d want 1", err_cnt - e0); end
  endtask
`else
  task automatic test_no_timeout();
    int n, e0;
    logic [9:0] seen;
    e0 = err_cnt;
    accept(8'h08, 8'h00, 1'b0);
    n = 0;
    while (bus.clk_drv_low && n < 6000) begin tick(1); n++; end
    device(4, 1'b1, seen);
    tick(1500);
    checks++; if (err_cnt - e0 !== 0) begin errors++; $display("FAIL nto_err: got %0d want 0", err_cnt - e0); end
    checks++; if (bus.tx_ready !== 1'b0) begin errors++; $display("FAIL nto_ready: got %b want 0", bus.tx_ready); end
    checks++; if (bus.data_drv_low !== 1'b0) begin errors++; $display("FAIL nto_bit3_drv: got %b want 0", bus.data_drv_low); end
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    dev_clk = 1'b1;
    tick(5);
    checks++; if (bus.tx_ready !== 1'b1) begin errors++; $display("FAIL nto_recover_ready: got %b want 1", bus.tx_ready); end
  endtask
`endif

  task automatic test_exclusive();
    checks++; if (both_cnt !== 0) begin errors++; $display("FAIL done_err_same_cycle: got %0d want 0", both_cnt); end
  endtask

  initial begin
    bus.tx_data = 8'h00;
    bus.tx_valid = 1'b0;
    test_reset();
    test_frame_ed();
    test_parity();
    test_no_ack();
    test_reset_mid_frame();
    test_back_to_back();
`ifdef PS2_TX_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    test_exclusive();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
